// File: rtl/seq_multiplier_if.sv
// Handshake and operand bundle between the execute stage and the iterative multiplier.
// The master side issues ops and kills; the slave side is the multiplier itself.
interface seq_multiplier_if #(
    parameter int WIDTH = 32
) ();
    logic             i_start;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_kill;
    logic             o_ready;
    logic             o_done;
    logic [WIDTH-1:0] o_out;

    modport master (
        output i_start, i_op, i_a, i_b, i_kill,
        input  o_ready, o_done, o_out
    );

    modport slave (
        input  i_start, i_op, i_a, i_b, i_kill,
        output o_ready, o_done, o_out
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative RV32M multiplier: sign-magnitude shift-add datapath retiring BITS_PER_CYCLE
// multiplier bits per clock, with a final sign fix-up and high/low half select.
module seq_multiplier #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2,
    parameter bit ZERO_BYPASS    = 1'b1
) (
    input logic              clk,
    input logic              rst,
    seq_multiplier_if.slave  bus
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic                          w_accept;
    logic [1:0]                    r_op;
    logic                          r_sa;
    logic                          r_sb;
    logic [WIDTH-1:0]              r_mcand;
    logic [WIDTH-1:0]              r_mplier;
    logic [2*WIDTH-1:0]            r_acc;
    logic [CW-1:0]                 r_cnt;
    logic [WIDTH-1:0]              r_out;

    logic                          w_sa;
    logic                          w_sb;
    logic                          w_zero;
    logic [WIDTH-1:0]              w_aMag;
    logic [WIDTH-1:0]              w_bMag;
    logic [WIDTH+BITS_PER_CYCLE-1:0] w_partial;
    logic [WIDTH+BITS_PER_CYCLE-1:0] w_sum;
    logic [2*WIDTH-1:0]            w_accNext;
    logic [2*WIDTH-1:0]            w_prod;
    logic [WIDTH-1:0]              w_result;

    assign w_sa   = bus.i_a[WIDTH-1] & ((bus.i_op == 2'b01) | (bus.i_op == 2'b10));
    assign w_sb   = bus.i_b[WIDTH-1] & (bus.i_op == 2'b01);
    assign w_aMag = w_sa ? -bus.i_a : bus.i_a;
    assign w_bMag = w_sb ? -bus.i_b : bus.i_b;
    assign w_zero = ZERO_BYPASS && ((bus.i_a == '0) || (bus.i_b == '0));

    // The accumulator shifts right as digits retire, so each partial product always
    // lands on the upper half; after N steps the full product sits in r_acc.
    assign w_partial = {{BITS_PER_CYCLE{1'b0}}, r_mcand}
                     * {{WIDTH{1'b0}}, r_mplier[BITS_PER_CYCLE-1:0]};
    assign w_sum     = {{BITS_PER_CYCLE{1'b0}}, r_acc[2*WIDTH-1:WIDTH]} + w_partial;
    assign w_accNext = {w_sum, r_acc[WIDTH-1:BITS_PER_CYCLE]};

    assign w_prod   = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_result = (r_op == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Kill outranks start everywhere; in IDLE/DONE it only suppresses acceptance.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        bus.o_ready = 1'b0;
        bus.o_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.o_ready = 1'b1;
                if (bus.i_start && !bus.i_kill) begin
                    w_accept = 1'b1;
                    w_next   = w_zero ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (bus.i_kill) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == LAST) begin
                    w_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_next = bus.i_kill ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                bus.o_ready = 1'b1;
                bus.o_done  = 1'b1;
                if (bus.i_start && !bus.i_kill) begin
                    w_accept = 1'b1;
                    w_next   = w_zero ? ST_DONE : ST_CALC;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_out    <= '0;
        end else if (w_accept) begin
            r_op     <= bus.i_op;
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_mcand  <= w_aMag;
            r_mplier <= w_bMag;
            r_acc    <= '0;
            r_cnt    <= '0;
            if (w_zero) begin
                r_out <= '0;
            end
        end else if (r_state == ST_CALC && !bus.i_kill) begin
            r_acc    <= w_accNext;
            r_mplier <= r_mplier >> BITS_PER_CYCLE;
            r_cnt    <= r_cnt + CW'(1);
        end else if (r_state == ST_FIX && !bus.i_kill) begin
            r_out <= w_result;
        end
    end

    assign bus.o_out = r_out;
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: directed cases on the default configuration, then random ops
// run in lockstep on 2-, 1- and 4-bit-per-cycle instances against an arithmetic model.
module tb_seq_multiplier;
    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        kill  = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic [2:0]  en    = 3'b001;
    int          checks   = 0;
    int          failures = 0;
    int          bpc[3]   = '{2, 1, 4};
    logic [2:0]  doneV;
    logic [2:0]  readyV;
    logic [31:0] outV[3];

    seq_multiplier_if #(.WIDTH(32)) busA ();
    seq_multiplier_if #(.WIDTH(32)) busB ();
    seq_multiplier_if #(.WIDTH(32)) busC ();

    seq_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(2), .ZERO_BYPASS(1'b1)) dutA (
        .clk(clk), .rst(rst), .bus(busA)
    );
    seq_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1), .ZERO_BYPASS(1'b1)) dutB (
        .clk(clk), .rst(rst), .bus(busB)
    );
    seq_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(4), .ZERO_BYPASS(1'b1)) dutC (
        .clk(clk), .rst(rst), .bus(busC)
    );

    assign busA.i_start = start & en[0];
    assign busB.i_start = start & en[1];
    assign busC.i_start = start & en[2];
    assign busA.i_op = op;  assign busB.i_op = op;  assign busC.i_op = op;
    assign busA.i_a  = a;   assign busB.i_a  = a;   assign busC.i_a  = a;
    assign busA.i_b  = b;   assign busB.i_b  = b;   assign busC.i_b  = b;
    assign busA.i_kill = kill;  assign busB.i_kill = kill;  assign busC.i_kill = kill;

    assign doneV  = {busC.o_done, busB.o_done, busA.o_done};
    assign readyV = {busC.o_ready, busB.o_ready, busA.o_ready};
    assign outV[0] = busA.o_out;
    assign outV[1] = busB.o_out;
    assign outV[2] = busC.o_out;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Full-precision product of the operands as the op code interprets them.
    function automatic logic [31:0] refModel(input logic [1:0] opIn, input logic [31:0] x,
                                             input logic [31:0] y);
        longint sx;
        longint sy;
        longint prod;
        sx = (opIn == 2'b01 || opIn == 2'b10) ? longint'($signed(x)) : longint'({32'b0, x});
        sy = (opIn == 2'b01) ? longint'($signed(y)) : longint'({32'b0, y});
        prod = sx * sy;
        return (opIn == 2'b00) ? prod[31:0] : prod[63:32];
    endfunction

    function automatic int refLatency(input int bitsPerCycle, input logic [31:0] x,
                                      input logic [31:0] y);
        return (x == 0 || y == 0) ? 1 : 32 / bitsPerCycle + 2;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Presents one op for a single edge, then scrambles the operand lines.
    task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] aIn,
                                 input logic [31:0] bIn);
        op = opIn;
        a = aIn;
        b = bIn;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 2'($urandom);
    endtask

    task automatic runDirected(input string tag, input logic [1:0] opIn, input logic [31:0] aIn,
                               input logic [31:0] bIn, input logic [31:0] expOut, input int expLat);
        int seen = 0;
        applyStimulus(opIn, aIn, bIn);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (doneV[0]) begin
                seen = cyc;
                break;
            end
            checkOutput({tag, "_busyReady"}, 64'(readyV[0]), 64'd0);
            tick();
        end
        checkOutput({tag, "_latency"}, 64'(seen), 64'(expLat));
        checkOutput({tag, "_out"}, 64'(outV[0]), 64'(expOut));
        checkOutput({tag, "_doneReady"}, 64'(readyV[0]), 64'd1);
    endtask

    task automatic expectQuiet(input string tag, input logic [31:0] expOut);
        logic sawDone = 1'b0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            if (doneV[0]) sawDone = 1'b1;
            tick();
        end
        checkOutput({tag, "_noDone"}, 64'(sawDone), 64'd0);
        checkOutput({tag, "_outHeld"}, 64'(outV[0]), 64'(expOut));
    endtask

    task automatic runRandom(input logic [1:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn);
        int seenAt[3] = '{0, 0, 0};
        logic [31:0] expOut = refModel(opIn, aIn, bIn);
        checkOutput("rnd_preReady", 64'(readyV), 64'd7);
        applyStimulus(opIn, aIn, bIn);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                if (doneV[k] && seenAt[k] == 0) begin
                    seenAt[k] = cyc;
                    checkOutput($sformatf("rnd op%0d a=%h b=%h bpc%0d out", opIn, aIn, bIn, bpc[k]),
                                64'(outV[k]), 64'(expOut));
                end
            end
            if (seenAt[0] != 0 && seenAt[1] != 0 && seenAt[2] != 0) break;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("rnd op%0d a=%h b=%h bpc%0d latency", opIn, aIn, bIn, bpc[k]),
                        64'(seenAt[k]), 64'(refLatency(bpc[k], aIn, bIn)));
        end
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_ready", 64'(readyV), 64'd7);
        checkOutput("reset_done", 64'(doneV), 64'd0);
        checkOutput("reset_out", 64'(outV[0]), 64'd0);

        runDirected("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 18);
        tick();
        checkOutput("done_pulse", 64'(doneV[0]), 64'd0);
        runDirected("mulh_minmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 18);
        runDirected("mulh_m1m1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 18);
        runDirected("mul_m1m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 18);
        runDirected("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18);
        runDirected("mulhsu_2", 2'b10, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001, 18);
        runDirected("bypass_zero", 2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1);
        runDirected("b2b_7x6", 2'b00, 32'd7, 32'd6, 32'd42, 18);
        tick();

        applyStimulus(2'b00, 32'd3, 32'd5);
        repeat (4) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        checkOutput("kill_ready", 64'(readyV[0]), 64'd1);
        checkOutput("kill_done", 64'(doneV[0]), 64'd0);
        expectQuiet("kill", 32'd42);

        kill = 1'b1;
        applyStimulus(2'b00, 32'd3, 32'd5);
        kill = 1'b0;
        checkOutput("killStart_ready", 64'(readyV[0]), 64'd1);
        expectQuiet("killStart", 32'd42);

        applyStimulus(2'b00, 32'd9, 32'd11);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midReset_out", 64'(outV[0]), 64'd0);
        checkOutput("midReset_done", 64'(doneV[0]), 64'd0);
        checkOutput("midReset_ready", 64'(readyV[0]), 64'd1);
        tick();

        en = 3'b111;
        for (int opc = 0; opc < 4; opc++) begin
            for (int n = 0; n < 200; n++) begin
                runRandom(2'(opc), pickOperand(), pickOperand());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
